// File: rtl/iic_device_model_pkg.sv
// Shared types for the I2C slave register-file model: FSM states and R/W bit values.
package iic_device_model_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } iic_state_t;

  localparam logic IIC_WRITE = 1'b0;
  localparam logic IIC_READ  = 1'b1;

endpackage

// File: rtl/iic_bus_monitor.sv
// Synchronises SCL/SDA into clk and produces single-cycle SCL edge and START/STOP pulses.
module iic_bus_monitor (
  input  logic clk,
  input  logic reset,
  input  logic scl_pin,
  input  logic sda_pin,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl;

  // Reset to the idle bus level so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_pin};
      sda_sync <= {sda_sync[0], sda_pin};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl      = scl_sync[1];
  assign sda      = sda_sync[1];
  assign scl_rise = scl & ~scl_prev;
  assign scl_fall = ~scl & scl_prev;
  assign start    = scl & scl_prev & sda_prev & ~sda;
  assign stop     = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/iic_device_model.sv
// I2C slave register file with address match, auto-incrementing pointer, read-only mask and
// a periodic status interrupt. SDA is open-drain: IIC_SDA_T=0 pulls the line low.
module iic_device_model
  import iic_device_model_pkg::*;
#(
  parameter logic [6:0]              DEVICE_ADDR     = 7'h53,
  parameter int                      REG_COUNT       = 64,
  parameter logic [REG_COUNT*8-1:0]  RESET_VALUES    = '0,
  parameter logic [REG_COUNT-1:0]    RO_MASK         = REG_COUNT'(1),
  parameter logic [7:0]              IRQ_ENABLE_ADDR = 8'h2E,
  parameter logic [7:0]              IRQ_STATUS_ADDR = 8'h30,
  parameter int                      IRQ_INTERVAL    = 300000
) (
  input  logic clk,
  input  logic reset,
  input  logic IIC_SCL_I,
  input  logic IIC_SDA_I,
  output logic IIC_SCL_O,
  output logic IIC_SDA_O,
  output logic IIC_SDA_T,
  output logic IRQ,
  output logic busy
);

  localparam int            PW       = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [PW-1:0] EN_IDX   = PW'(IRQ_ENABLE_ADDR);
  localparam logic [PW-1:0] ST_IDX   = PW'(IRQ_STATUS_ADDR);
  localparam logic [31:0]   INTERVAL = 32'(IRQ_INTERVAL);

  iic_state_t    state, state_next;
  logic [3:0]    bit_cnt;
  logic [7:0]    rx;
  logic [7:0]    tx;
  logic          master_nack;
  logic [PW-1:0] ptr, ptr_inc;
  logic [7:0]    regs [REG_COUNT];
  logic [31:0]   timer;
  logic          irq_q, busy_q, sda_t_q, drive_low;
  logic          sda, scl_rise, scl_fall, start, stop;
  logic          byte_done, addr_match, status_clear, bus_write;

  iic_bus_monitor u_mon (
    .clk      (clk),
    .reset    (reset),
    .scl_pin  (IIC_SCL_I),
    .sda_pin  (IIC_SDA_I),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign ptr_inc      = (ptr == PW'(REG_COUNT - 1)) ? '0 : ptr + 1'b1;
  assign byte_done    = scl_fall && (bit_cnt == 4'd8);
  assign addr_match   = (rx[7:1] == DEVICE_ADDR);
  assign status_clear = (state == RD_ACK) && scl_fall && (ptr == ST_IDX);
  assign bus_write    = (state == WR_ACK) && scl_fall && !RO_MASK[ptr] && (ptr != ST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Phase changes happen on SCL fall so SDA only moves while SCL is low.
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = IDLE;
    end else if (start) begin
      state_next = ADDR;
    end else begin
      case (state)
        ADDR:     if (byte_done) state_next = addr_match ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall) state_next = (rx[0] == IIC_READ) ? RD_DATA : PTR;
        PTR:      if (byte_done) state_next = PTR_ACK;
        PTR_ACK:  if (scl_fall) state_next = WR_DATA;
        WR_DATA:  if (byte_done) state_next = WR_ACK;
        WR_ACK:   if (scl_fall) state_next = WR_DATA;
        RD_DATA:  if (scl_fall && bit_cnt == 4'd7) state_next = RD_ACK;
        RD_ACK:   if (scl_fall) state_next = master_nack ? IGNORE : RD_DATA;
        default:  state_next = state;
      endcase
    end
  end

  always_comb begin
    drive_low = 1'b0;
    case (state)
      ADDR_ACK, PTR_ACK, WR_ACK: drive_low = 1'b1;
      RD_DATA:                   drive_low = ~tx[7];
      default:                   drive_low = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= '0;
      rx          <= '0;
      tx          <= '0;
      master_nack <= 1'b1;
      ptr         <= '0;
      busy_q      <= 1'b0;
      sda_t_q     <= 1'b1;
    end else begin
      sda_t_q <= ~drive_low;
      if (stop)                                         busy_q <= 1'b0;
      else if (state == ADDR && byte_done && addr_match) busy_q <= 1'b1;

      if (start || stop) begin
        bit_cnt <= '0;
      end else if (scl_rise) begin
        if (state == ADDR || state == PTR || state == WR_DATA) begin
          rx      <= {rx[6:0], sda};
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (state == RD_ACK) master_nack <= sda;
      end else if (scl_fall) begin
        case (state)
          ADDR, PTR, WR_DATA: if (bit_cnt == 4'd8) bit_cnt <= '0;
          ADDR_ACK: if (rx[0] == IIC_READ) tx <= regs[ptr];
          PTR_ACK:  ptr <= PW'(int'(rx) % REG_COUNT);
          WR_ACK:   ptr <= ptr_inc;
          RD_DATA: begin
            tx      <= {tx[6:0], 1'b0};
            bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
          end
          // The pointer advances on every completed read byte, ACKed or not.
          RD_ACK: begin
            ptr <= ptr_inc;
            tx  <= regs[ptr_inc];
          end
          default: ;
        endcase
      end
    end
  end

  // Status clear by a completed read takes priority over a simultaneous expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= RESET_VALUES[8*i +: 8];
      timer <= INTERVAL;
      irq_q <= 1'b0;
    end else begin
      if (bus_write) regs[ptr] <= rx;
      if (status_clear) begin
        regs[ST_IDX][7] <= 1'b0;
        irq_q           <= 1'b0;
        timer           <= INTERVAL;
      end else if (regs[EN_IDX] == 8'h00) begin
        timer <= INTERVAL;
      end else if (timer != 32'd0) begin
        timer <= timer - 32'd1;
      end else begin
        irq_q           <= 1'b1;
        regs[ST_IDX][7] <= 1'b1;
      end
    end
  end

  assign IIC_SCL_O = 1'b1;
  assign IIC_SDA_O = 1'b0;
  assign IIC_SDA_T = sda_t_q;
  assign IRQ       = irq_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_iic_device_model.sv
// Directed and randomized I2C master transactions against a register-file reference model.
module tb_iic_device_model;
  import iic_device_model_pkg::*;

  localparam int Q = 8;

  function automatic logic [7:0] rv(input int n);
    if (n == 8'h2E || n == 8'h30) return 8'h00;
    return 8'(n * 37 + 11);
  endfunction

  function automatic logic [511:0] init_vec();
    logic [511:0] v;
    for (int i = 0; i < 64; i++) v[8*i +: 8] = rv(i);
    return v;
  endfunction

  localparam logic [511:0] RV   = init_vec();
  localparam logic [63:0]  RO_M = 64'h1;

  logic clk = 1'b0;
  logic rst;
  logic scl_m, sda_m, sda_bus;
  logic IIC_SCL_O, IIC_SDA_O, IIC_SDA_T, IRQ, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int viol = 0;
  int sda_low_cnt = 0;
  int fall_cyc = 0;
  logic sda_t_q = 1'b1;
  logic rst_q = 1'b1;

  logic [7:0] m_regs [64];
  int         m_ptr;
  logic [7:0] wbuf [4];

  assign sda_bus = sda_m & (IIC_SDA_T | IIC_SDA_O);

  iic_device_model #(
    .DEVICE_ADDR     (7'h53),
    .REG_COUNT       (64),
    .RESET_VALUES    (RV),
    .RO_MASK         (RO_M),
    .IRQ_ENABLE_ADDR (8'h2E),
    .IRQ_STATUS_ADDR (8'h30),
    .IRQ_INTERVAL    (100)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .IIC_SCL_I (scl_m),
    .IIC_SDA_I (sda_bus),
    .IIC_SCL_O (IIC_SCL_O),
    .IIC_SDA_O (IIC_SDA_O),
    .IIC_SDA_T (IIC_SDA_T),
    .IRQ       (IRQ),
    .busy      (busy)
  );

  // Clock / monitors
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rst_q   <= rst;
    sda_t_q <= IIC_SDA_T;
    if (!rst && !rst_q && scl_m && (IIC_SDA_T !== sda_t_q)) viol <= viol + 1;
    if (IIC_SDA_T === 1'b0) sda_low_cnt <= sda_low_cnt + 1;
  end

  initial begin
    #950000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(Q);
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;    wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    scl_m = 1'b0; fall_cyc = cyc; wait_clks(Q);
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q / 2);
    b = sda_bus;  wait_clks(Q / 2);
    scl_m = 1'b0; fall_cyc = cyc; wait_clks(Q);
  endtask

  task automatic put_byte(input logic [7:0] d, output logic nack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(nack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  // Reference-model transactions
  task automatic do_write(input logic [7:0] p, input int n, input string tag);
    logic nack;
    i2c_start();
    put_byte({7'h53, IIC_WRITE}, nack); check({tag, "_aack"}, nack, 1'b0);
    put_byte(p, nack);                  check({tag, "_pack"}, nack, 1'b0);
    m_ptr = p % 64;
    for (int i = 0; i < n; i++) begin
      put_byte(wbuf[i], nack); check($sformatf("%s_dack%0d", tag, i), nack, 1'b0);
      if (m_ptr != 8'h30 && !RO_M[m_ptr]) m_regs[m_ptr] = wbuf[i];
      m_ptr = (m_ptr + 1) % 64;
    end
    check({tag, "_busy"}, busy, 1'b1);
    i2c_stop();
    wait_clks(4);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic do_read(input logic [7:0] p, input bit set_ptr, input int n, input string tag);
    logic nack;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      put_byte({7'h53, IIC_WRITE}, nack); check({tag, "_wack"}, nack, 1'b0);
      put_byte(p, nack);                  check({tag, "_pack"}, nack, 1'b0);
      m_ptr = p % 64;
      i2c_start();
    end
    put_byte({7'h53, IIC_READ}, nack); check({tag, "_rack"}, nack, 1'b0);
    for (int i = 0; i < n; i++) begin
      get_byte(d, (i == n - 1));
      check($sformatf("%s_b%0d", tag, i), d, m_regs[m_ptr]);
      if (m_ptr == 8'h30) m_regs[m_ptr][7] = 1'b0;
      m_ptr = (m_ptr + 1) % 64;
    end
    i2c_stop();
  endtask

  task automatic wait_irq(input string tag, input int base);
    int k = 0;
    int dt;
    while (IRQ !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    dt = cyc - base;
    check({tag, "_seen"}, IRQ, 1'b1);
    check({tag, "_lat"}, (dt >= 100 && dt <= 110), 1'b1);
  endtask

  initial begin
    logic nack;
    int   low0, p, n;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    for (int i = 0; i < 64; i++) m_regs[i] = rv(i);
    m_ptr = 0;
    wait_clks(4);
    check("rst_sda_t", IIC_SDA_T, 1'b1);
    check("rst_irq", IRQ, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("scl_o", IIC_SCL_O, 1'b1);
    check("sda_o", IIC_SDA_O, 1'b0);
    rst = 1'b0;
    wait_clks(10);

    // Simple write then readback
    wbuf[0] = 8'h08;
    do_write(8'h2D, 1, "a");
    do_read(8'h2D, 1, 1, "a_rd");

    // Burst read with repeated START, pointer continues at 0x38
    do_read(8'h32, 1, 6, "b_rd");
    do_read(8'h00, 0, 1, "b_ptr");

    // Foreign address is never acknowledged
    low0 = sda_low_cnt;
    i2c_start();
    put_byte({7'h1D, IIC_WRITE}, nack); check("c_nack", nack, 1'b1);
    put_byte(8'h10, nack);
    put_byte(8'h55, nack);
    check("c_busy", busy, 1'b0);
    i2c_stop();
    wait_clks(4);
    check("c_sda_t", sda_low_cnt - low0, 0);
    do_read(8'h10, 1, 1, "c_rd");

    // Pointer wrap over a read-only register
    wbuf[0] = 8'hAA; wbuf[1] = 8'hBB;
    do_write(8'h3F, 2, "d");
    do_read(8'h00, 0, 1, "d_ptr");
    do_read(8'h3F, 1, 2, "d_wrap");

    // Pointer byte beyond REG_COUNT is taken modulo
    wbuf[0] = 8'h77;
    do_write(8'h45, 1, "e");
    do_read(8'h05, 1, 1, "e_rd");

    // Status register is not bus-writable
    wbuf[0] = 8'h55;
    do_write(8'h30, 1, "st_wr");
    do_read(8'h30, 1, 1, "st_rd");

    // Randomized bursts
    for (int it = 0; it < 8; it++) begin
      p = $urandom_range(0, 40);
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) wbuf[j] = 8'($urandom);
      do_write(8'(p), n, $sformatf("r%0d_w", it));
      do_read(8'(p), 1, n, $sformatf("r%0d_r", it));
    end

    // Interrupt timer, status read clears and restarts it
    check("irq_idle", IRQ, 1'b0);
    wbuf[0] = 8'h80;
    do_write(8'h2E, 1, "irq_en");
    wait_irq("irq1", fall_cyc);
    m_regs[8'h30][7] = 1'b1;
    do_read(8'h30, 1, 1, "irq_st");
    check("irq_cleared", IRQ, 1'b0);
    wait_irq("irq2", fall_cyc);

    // Reset in the middle of a read data byte
    wbuf[0] = 8'h00;
    do_write(8'h05, 1, "z_prep");
    i2c_start();
    put_byte({7'h53, IIC_WRITE}, nack); check("z_wack", nack, 1'b0);
    put_byte(8'h05, nack);              check("z_pack", nack, 1'b0);
    i2c_start();
    put_byte({7'h53, IIC_READ}, nack);  check("z_rack", nack, 1'b0);
    check("z_drive", IIC_SDA_T, 1'b0);
    scl_m = 1'b1;
    wait_clks(2);
    rst = 1'b1;
    #1;
    check("z_release", IIC_SDA_T, 1'b1);
    check("z_busy", busy, 1'b0);
    check("z_irq", IRQ, 1'b0);
    wait_clks(3);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) m_regs[i] = rv(i);
    m_ptr = 0;
    scl_m = 1'b0;
    wait_clks(Q);
    i2c_stop();
    do_read(8'h00, 0, 1, "z_rd0");
    do_read(8'h05, 1, 1, "z_rd5");
    wbuf[0] = 8'h5A;
    do_write(8'h2D, 1, "z_w");
    do_read(8'h2D, 1, 1, "z_rd");

    check("sda_t_timing", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
